// File: rtl/aes_inv_keysched_32.sv
// Streaming inverse AES-128 key schedule, 32-bit words.
// Accepts the round-10 key (w40..w43) and emits w43 down to w0, one word per
// output handshake, deriving each word from a 4-word sliding window.
module aes_inv_keysched_32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_key,
   output logic [3:0]  out_round,
   output logic        out_last
);

   // Forward AES S-box, byte 0x00 in the most significant position.
   localparam logic [2047:0] SboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SboxTable[{~b, 3'b000} +: 8];
   endfunction

   // r is j/4, so the constant used is Rcon[r+1].
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      unique case (r)
         4'd0:    c = 8'h01;
         4'd1:    c = 8'h02;
         4'd2:    c = 8'h04;
         4'd3:    c = 8'h08;
         4'd4:    c = 8'h10;
         4'd5:    c = 8'h20;
         4'd6:    c = 8'h40;
         4'd7:    c = 8'h80;
         4'd8:    c = 8'h1b;
         4'd9:    c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   typedef enum logic [0:0] {StLoad, StRun} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [5:0]  idx_q, idx_d;
   logic [31:0] win_q [4];
   logic [31:0] win_d [4];
   logic [31:0] out_key_q, out_key_d;
   logic [3:0]  out_round_q, out_round_d;
   logic        out_last_q, out_last_d;

   logic        in_hs, out_hs;
   logic [5:0]  j;
   logic [31:0] rot, sub, next_word;

   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StLoad;
      else        state_q <= state_d;
   end

   // FSM next state: LOAD ends on the 4th word, RUN ends on the w0 handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:  if (in_hs && cnt_q == 2'd3) state_d = StRun;
         StRun:   if (out_hs && idx_q == 6'd0) state_d = StLoad;
         default: state_d = StLoad;
      endcase
   end

   // FSM outputs; both decode straight from the state flop.
   always_comb begin
      in_ready  = (state_q == StLoad);
      out_valid = (state_q == StRun);
   end

   // Next-word derivation; window word k holds w[idx+k], so w[j+4]=win[3], w[j+3]=win[2].
   always_comb begin
      j   = idx_q - 6'd1;
      rot = {win_q[2][23:0], win_q[2][31:24]};
      sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      if (j[1:0] == 2'd0) next_word = win_q[3] ^ sub ^ {rcon(j[5:2]), 24'h0};
      else                next_word = win_q[3] ^ win_q[2];
   end

   // Datapath next state: load words, then step the output word on each handshake.
   always_comb begin
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      win_d       = win_q;
      out_key_d   = out_key_q;
      out_round_d = out_round_q;
      out_last_d  = out_last_q;
      if (state_q == StLoad) begin
         if (in_hs) begin
            win_d[cnt_q] = in_key;
            cnt_d        = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               idx_d       = 6'd43;
               out_key_d   = in_key;
               out_round_d = 4'd10;
               out_last_d  = 1'b0;
            end
         end
      end else if (out_hs) begin
         if (idx_q == 6'd0) begin
            cnt_d = 2'd0;
         end else begin
            idx_d       = j;
            out_round_d = j[5:2];
            out_last_d  = (j == 6'd0);
            if (idx_q > 6'd40) begin
               // w42..w40 come straight from the loaded registers (j-40 == j[1:0]).
               out_key_d = win_q[j[1:0]];
            end else begin
               out_key_d = next_word;
               win_d[3]  = win_q[2];
               win_d[2]  = win_q[1];
               win_d[1]  = win_q[0];
               win_d[0]  = next_word;
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= 2'd0;
         idx_q       <= 6'd0;
         win_q       <= '{default: '0};
         out_key_q   <= 32'h0;
         out_round_q <= 4'd0;
         out_last_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         win_q       <= win_d;
         out_key_q   <= out_key_d;
         out_round_q <= out_round_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_key   = out_key_q;
   assign out_round = out_round_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_aes_inv_keysched_32.sv
// Bench for aes_inv_keysched_32: expected words come from a forward key
// expansion using a GF(2^8)-derived S-box and are queued per loaded key.
module tb_aes_inv_keysched_32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_key;
   logic [3:0]  out_round;
   logic        out_last;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;

   logic [31:0] ws [2][44];
   logic [36:0] exp_q [$];

   aes_inv_keysched_32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_key   (out_key),
      .out_round (out_round),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as affine(a^254) in GF(2^8).
   function automatic logic [7:0] ref_sbox(input logic [7:0] a);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 0; i < 254; i++) v = gmul(v, a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
             ^ 8'h63;
   endfunction

   task automatic expand(input logic [127:0] k, input int s);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) ws[s][i] = k[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = ws[s][i - 1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
            t[31:24] = t[31:24] ^ rc;
            rc = xtime(rc);
         end
         ws[s][i] = ws[s][i - 4] ^ t;
      end
   endtask

   task automatic push_stream(input int s);
      logic [3:0] r;
      for (int i = 43; i >= 0; i--) begin
         r = 4'(i >> 2);
         exp_q.push_back({ws[s][i], r, (i == 0)});
      end
   endtask

   // Presents w40..w43 of key s on four consecutive cycles (block must be in LOAD).
   task automatic load_key(input int s);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_key   = ws[s][40 + i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_key = '0; out_ready = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_key !== 32'h0) begin bad++; $display("FAIL reset_out_key got=%h exp=0", out_key); end
      total++; if (out_round !== 4'd0) begin bad++; $display("FAIL reset_out_round got=%0d exp=0", out_round); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_stream;
      int guard;
      logic [36:0] e;
      push_stream(0);
      load_key(0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         out_ready = 1'b1;
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1) begin
            bad++; $display("FAIL stream_continuous got out_valid=%b exp=1 at word %0d", out_valid, guard);
         end else begin
            e = exp_q.pop_front();
            total++;
            if ({out_key, out_round, out_last} !== e)
               begin bad++; $display("FAIL stream_word got=%h/%0d/%b exp=%h/%0d/%b", out_key,
                                     out_round, out_last, e[36:5], e[4:1], e[0]); end
         end
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      total++; if (guard != 44) begin bad++; $display("FAIL stream_cycles got=%0d exp=44", guard); end
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin bad++; $display("FAIL stream_reload got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
      exp_q.delete();
   endtask

   task automatic test_backpressure;
      int guard;
      bit held_v;
      logic [36:0] held, cur, e;
      push_stream(0);
      load_key(0);
      guard = 0; held_v = 1'b0; held = '0;
      while (exp_q.size() > 0 && guard < 2000) begin
         out_ready = ($urandom_range(0, 99) < 30);
         @(negedge clk);
         cur = {out_key, out_round, out_last};
         if (held_v) begin
            total++;
            if (out_valid !== 1'b1 || cur !== held)
               begin bad++; $display("FAIL bp_stable got=%h exp=%h valid=%b", cur, held, out_valid); end
         end
         held_v = out_valid && !out_ready;
         held   = cur;
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            total++;
            if (cur !== e) begin bad++; $display("FAIL bp_word got=%h exp=%h", cur, e); end
         end
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_timeout got=%0d left exp=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_input_during_run;
      int guard;
      logic [36:0] e;
      push_stream(0);
      load_key(0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 2000) begin
         in_valid  = 1'b1;
         in_key    = $urandom;
         out_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin bad++; $display("FAIL run_in_ready got in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid); end
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            total++;
            if ({out_key, out_round, out_last} !== e)
               begin bad++; $display("FAIL run_word got=%h exp=%h", out_key, e[36:5]); end
         end
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL run_timeout got=%0d left exp=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_run;
      int n;
      int guard;
      logic [36:0] e;
      push_stream(0);
      load_key(0);
      n = 0;
      while (n < 17) begin
         out_ready = 1'b1;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (out_valid !== 1'b1 || {out_key, out_round, out_last} !== e)
            begin bad++; $display("FAIL rst_pre_word got=%h exp=%h", out_key, e[36:5]); end
         @(posedge clk); #1;
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      push_stream(0);
      load_key(0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         out_ready = 1'b1;
         @(negedge clk);
         if (out_valid) begin
            e = exp_q.pop_front();
            total++;
            if ({out_key, out_round, out_last} !== e)
               begin bad++; $display("FAIL rst_post_word got=%h exp=%h", out_key, e[36:5]); end
         end
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rst_timeout got=%0d left exp=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back;
      int t0, t1;
      push_stream(0);
      push_stream(1);
      t0 = 0; t1 = 0;
      fork
         begin
            bit hs;
            int g;
            for (int w = 0; w < 8; w++) begin
               hs = 1'b0; g = 0;
               in_valid = 1'b1;
               in_key   = ws[w / 4][40 + w % 4];
               while (!hs && g < 500) begin
                  @(negedge clk);
                  hs = in_ready;
                  @(posedge clk); #1;
                  g++;
               end
               if (!hs) begin total++; bad++; $display("FAIL b2b_load_timeout got word=%0d exp=accepted", w); end
            end
            in_valid = 1'b0;
         end
         begin
            int n;
            int g;
            logic [36:0] e;
            n = 0; g = 0;
            while (exp_q.size() > 0 && g < 1000) begin
               out_ready = 1'b1;
               @(negedge clk);
               if (out_valid) begin
                  e = exp_q.pop_front();
                  total++;
                  if ({out_key, out_round, out_last} !== e)
                     begin bad++; $display("FAIL b2b_word got=%h exp=%h n=%0d", out_key, e[36:5], n); end
                  if (n == 43) t0 = cyc_cnt;
                  if (n == 44) t1 = cyc_cnt;
                  n++;
               end
               @(posedge clk); #1;
               g++;
            end
            out_ready = 1'b0;
         end
      join
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_timeout got=%0d left exp=0", exp_q.size()); end
      total++; if (t1 - t0 != 5) begin bad++; $display("FAIL b2b_gap got=%0d exp=5", t1 - t0); end
      exp_q.delete();
   endtask

   task automatic test_partial_load;
      int guard;
      logic [36:0] e;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_key   = ws[1][40 + i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_stream(0);
      load_key(0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         out_ready = 1'b1;
         @(negedge clk);
         if (out_valid) begin
            e = exp_q.pop_front();
            total++;
            if ({out_key, out_round, out_last} !== e)
               begin bad++; $display("FAIL partial_word got=%h exp=%h", out_key, e[36:5]); end
         end
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL partial_timeout got=%0d left exp=0", exp_q.size()); end
      exp_q.delete();
   endtask

   initial begin
      expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
      expand(128'h000102030405060708090a0b0c0d0e0f, 1);
      test_reset();
      test_stream();
      test_backpressure();
      test_input_during_run();
      test_reset_mid_run();
      test_back_to_back();
      test_partial_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
